// File: rtl/ysyx_22040632_axi_master_pkg.sv
// Shared types and AXI4 constants for the data-cache AXI master.
package ysyx_22040632_axi_master_pkg;

  typedef enum logic {
    REQ_READ  = 1'b0,
    REQ_WRITE = 1'b1
  } rw_req_e;

  typedef enum logic [2:0] {
    AXI_SIZE_BYTES_1 = 3'd0,
    AXI_SIZE_BYTES_2 = 3'd1,
    AXI_SIZE_BYTES_4 = 3'd2,
    AXI_SIZE_BYTES_8 = 3'd3
  } axi_size_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_AW   = 3'd3,
    ST_W    = 3'd4,
    ST_B    = 3'd5,
    ST_DONE = 3'd6
  } axi_state_e;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != AXI_RESP_OKAY;
  endfunction

endpackage

// File: rtl/ysyx_22040632_axi_master.sv
// Cache-side request port to AXI4 master bridge, one transaction in flight, INCR bursts.
// Optional YSYX_22040632_AXI_RESP_CHECK_EN adds a sticky rw_err flag for non-OKAY responses.
module ysyx_22040632_axi_master
  import ysyx_22040632_axi_master_pkg::*;
#(
  parameter int ID_W   = 4,
  parameter int AXI_ID = 0,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                rrst_n,
  input  logic                rw_valid,
  input  logic                rw_req,
  input  logic [ADDR_W-1:0]   rw_addr,
  input  logic [2:0]          rw_size,
  input  logic [7:0]          rw_len,
  input  logic [DATA_W-1:0]   rw_w_data,
  input  logic [DATA_W/8-1:0] w_strb,
  output logic                rw_ready,
  output logic [DATA_W-1:0]   data_read,
  output logic                r_hs,
  output logic                r_last,
  output logic                w_hs,
  output logic                w_last,
  output logic                axi_write_ahead,
`ifdef YSYX_22040632_AXI_RESP_CHECK_EN
  output logic                rw_err,
`endif
  output logic [ID_W-1:0]     awid,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready,
  output logic [ID_W-1:0]     arid,
  output logic [ADDR_W-1:0]   araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic                arvalid,
  input  logic                arready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready
);

  axi_state_e          state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [2:0]          size_q;
  logic [7:0]          len_q;
  logic [7:0]          beat_cnt_q;
  logic                arvalid_q;
  logic                rready_q;
  logic                awvalid_q;
  logic                wvalid_q;
  logic                bready_q;
  logic                rw_ready_q;
  logic                ahead_q;
  logic [DATA_W-1:0]   data_read_q;
  logic                last_beat_s;
`ifdef YSYX_22040632_AXI_RESP_CHECK_EN
  logic                err_q;
  assign rw_err = err_q;
`else
  logic                unused_resp_s;
  assign unused_resp_s = ^{rresp, bresp};
`endif

  // Handshake strobes are combinational so the cache can advance its beat pointer in the same cycle.
  assign r_hs        = rvalid && rready_q;
  assign r_last      = r_hs && rlast;
  assign last_beat_s = (beat_cnt_q == len_q);
  assign w_hs        = wvalid_q && wready;
  assign w_last      = w_hs && wlast;

  assign awid    = ID_W'(AXI_ID);
  assign awaddr  = addr_q;
  assign awlen   = len_q;
  assign awsize  = size_q;
  assign awburst = AXI_BURST_INCR;
  assign awvalid = awvalid_q;
  assign wdata   = rw_w_data;
  assign wstrb   = w_strb;
  assign wlast   = wvalid_q && last_beat_s;
  assign wvalid  = wvalid_q;
  assign bready  = bready_q;
  assign arid    = ID_W'(AXI_ID);
  assign araddr  = addr_q;
  assign arlen   = len_q;
  assign arsize  = size_q;
  assign arburst = AXI_BURST_INCR;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;

  assign rw_ready        = rw_ready_q;
  assign data_read       = data_read_q;
  assign axi_write_ahead = ahead_q;

  // Transaction FSM; every channel control is a register set on state entry.
  always_ff @(posedge clk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      size_q      <= 3'd0;
      len_q       <= 8'd0;
      beat_cnt_q  <= 8'd0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      rw_ready_q  <= 1'b0;
      ahead_q     <= 1'b0;
      data_read_q <= '0;
`ifdef YSYX_22040632_AXI_RESP_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rw_valid) begin
            addr_q <= rw_addr;
            size_q <= rw_size;
            len_q  <= rw_len;
`ifdef YSYX_22040632_AXI_RESP_CHECK_EN
            err_q  <= 1'b0;
`endif
            if (rw_req == REQ_WRITE) begin
              state_q   <= ST_AW;
              awvalid_q <= 1'b1;
              ahead_q   <= 1'b1;
            end else begin
              state_q   <= ST_AR;
              arvalid_q <= 1'b1;
            end
          end
        end
        ST_AR: begin
          if (arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= ST_R;
          end
        end
        ST_R: begin
          if (r_hs) begin
            data_read_q <= rdata;
`ifdef YSYX_22040632_AXI_RESP_CHECK_EN
            if (resp_is_err(rresp)) begin
              err_q <= 1'b1;
            end
`endif
            if (rlast) begin
              rready_q   <= 1'b0;
              rw_ready_q <= 1'b1;
              state_q    <= ST_DONE;
            end
          end
        end
        ST_AW: begin
          if (awready) begin
            awvalid_q  <= 1'b0;
            ahead_q    <= 1'b0;
            wvalid_q   <= 1'b1;
            beat_cnt_q <= 8'd0;
            state_q    <= ST_W;
          end
        end
        ST_W: begin
          // Counter holds at len on the final beat so it never runs past the burst.
          if (w_hs) begin
            if (last_beat_s) begin
              wvalid_q <= 1'b0;
              bready_q <= 1'b1;
              state_q  <= ST_B;
            end else begin
              beat_cnt_q <= beat_cnt_q + 8'd1;
            end
          end
        end
        ST_B: begin
          if (bvalid) begin
`ifdef YSYX_22040632_AXI_RESP_CHECK_EN
            if (resp_is_err(bresp)) begin
              err_q <= 1'b1;
            end
`endif
            bready_q   <= 1'b0;
            rw_ready_q <= 1'b1;
            state_q    <= ST_DONE;
          end
        end
        ST_DONE: begin
          rw_ready_q <= 1'b0;
          state_q    <= ST_IDLE;
        end
        default: begin
          arvalid_q  <= 1'b0;
          rready_q   <= 1'b0;
          awvalid_q  <= 1'b0;
          wvalid_q   <= 1'b0;
          bready_q   <= 1'b0;
          rw_ready_q <= 1'b0;
          ahead_q    <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22040632_axi_master.sv
// Directed bench for ysyx_22040632_axi_master with a transaction-level reference model.
module tb_ysyx_22040632_axi_master;

  logic        clk = 1'b0;
  logic        rrst_n = 1'b0;
  logic        rw_valid, rw_req;
  logic [31:0] rw_addr;
  logic [2:0]  rw_size;
  logic [7:0]  rw_len;
  logic [63:0] rw_w_data;
  logic [7:0]  w_strb;
  logic        rw_ready, r_hs, r_last, w_hs, w_last, axi_write_ahead;
  logic [63:0] data_read;
  logic [3:0]  awid, arid;
  logic [31:0] awaddr, araddr;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [63:0] wdata, rdata;
  logic [7:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        arvalid, arready, rlast, rvalid, rready;
`ifdef YSYX_22040632_AXI_RESP_CHECK_EN
  logic        rw_err;
`endif

  always #5 clk = ~clk;

  ysyx_22040632_axi_master dut (
    .clk(clk), .rrst_n(rrst_n), .rw_valid(rw_valid), .rw_req(rw_req), .rw_addr(rw_addr),
    .rw_size(rw_size), .rw_len(rw_len), .rw_w_data(rw_w_data), .w_strb(w_strb),
    .rw_ready(rw_ready), .data_read(data_read), .r_hs(r_hs), .r_last(r_last), .w_hs(w_hs),
    .w_last(w_last), .axi_write_ahead(axi_write_ahead),
`ifdef YSYX_22040632_AXI_RESP_CHECK_EN
    .rw_err(rw_err),
`endif
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: where in a transaction we are, as seen from the bus.
  typedef enum int {M_IDLE, M_ADDR, M_DATA, M_RESP, M_DONE} mph_e;
  mph_e        ph = M_IDLE;
  logic        cur_wr = 1'b0;
  logic [31:0] cur_addr = 32'd0;
  logic [2:0]  cur_size = 3'd0;
  logic [7:0]  cur_len = 8'd0;
  int          wbeat = 0;
  logic [63:0] exp_data = 64'd0;
  logic        stall_prev = 1'b0;
  logic [63:0] prev_wdata = 64'd0;
  logic        exp_err = 1'b0;
  int          n_done = 0;

  initial begin
    logic rhs, whs;
    forever begin
      @(negedge clk);
      if (!rrst_n) begin
        chk("rst_arvalid", 64'(arvalid), 64'd0);
        chk("rst_awvalid", 64'(awvalid), 64'd0);
        chk("rst_wvalid", 64'(wvalid), 64'd0);
        chk("rst_rready", 64'(rready), 64'd0);
        chk("rst_bready", 64'(bready), 64'd0);
        chk("rst_rw_ready", 64'(rw_ready), 64'd0);
        chk("rst_data_read", data_read, 64'd0);
        ph = M_IDLE;
        exp_data = 64'd0;
        stall_prev = 1'b0;
      end else begin
        rhs = rvalid && ph == M_DATA && !cur_wr;
        whs = wready && ph == M_DATA && cur_wr;
        chk("data_read", data_read, exp_data);
        chk("rw_ready", 64'(rw_ready), 64'(ph == M_DONE));
        chk("arvalid", 64'(arvalid), 64'(ph == M_ADDR && !cur_wr));
        chk("awvalid", 64'(awvalid), 64'(ph == M_ADDR && cur_wr));
        chk("write_ahead", 64'(axi_write_ahead), 64'(ph == M_ADDR && cur_wr));
        chk("rready", 64'(rready), 64'(ph == M_DATA && !cur_wr));
        chk("wvalid", 64'(wvalid), 64'(ph == M_DATA && cur_wr));
        chk("bready", 64'(bready), 64'(ph == M_RESP));
        chk("r_hs", 64'(r_hs), 64'(rhs));
        chk("r_last", 64'(r_last), 64'(rhs && rlast));
        chk("w_hs", 64'(w_hs), 64'(whs));
        chk("w_last", 64'(w_last), 64'(whs && wbeat == int'(cur_len)));
        case (ph)
          M_IDLE: if (rw_valid) begin
            cur_wr = rw_req; cur_addr = rw_addr; cur_size = rw_size; cur_len = rw_len;
            exp_err = 1'b0; ph = M_ADDR;
          end
          M_ADDR: if (cur_wr) begin
            chk("awaddr", 64'(awaddr), 64'(cur_addr));
            chk("awlen", 64'(awlen), 64'(cur_len));
            chk("awsize", 64'(awsize), 64'(cur_size));
            chk("awburst", 64'(awburst), 64'd1);
            chk("awid", 64'(awid), 64'd0);
            if (awready) begin ph = M_DATA; wbeat = 0; stall_prev = 1'b0; end
          end else begin
            chk("araddr", 64'(araddr), 64'(cur_addr));
            chk("arlen", 64'(arlen), 64'(cur_len));
            chk("arsize", 64'(arsize), 64'(cur_size));
            chk("arburst", 64'(arburst), 64'd1);
            chk("arid", 64'(arid), 64'd0);
            if (arready) ph = M_DATA;
          end
          M_DATA: if (cur_wr) begin
            chk("wdata", wdata, rw_w_data);
            chk("wstrb", 64'(wstrb), 64'(w_strb));
            chk("wlast", 64'(wlast), 64'(wbeat == int'(cur_len)));
            if (stall_prev) chk("wdata_stable", wdata, prev_wdata);
            stall_prev = !wready;
            prev_wdata = wdata;
            if (wready) begin
              if (wbeat == int'(cur_len)) ph = M_RESP;
              else wbeat++;
            end
          end else if (rvalid) begin
            exp_data = rdata;
            if (rresp != 2'b00) exp_err = 1'b1;
            if (rlast) ph = M_DONE;
          end
          M_RESP: if (bvalid) begin
            if (bresp != 2'b00) exp_err = 1'b1;
            ph = M_DONE;
          end
          M_DONE: begin
`ifdef YSYX_22040632_AXI_RESP_CHECK_EN
            chk("rw_err", 64'(rw_err), 64'(exp_err));
`endif
            n_done++;
            ph = M_IDLE;
          end
          default: ph = M_IDLE;
        endcase
      end
    end
  end

  int gaps[8] = '{0, 2, 1, 0, 3, 0, 1, 2};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rbeat(input logic [31:0] a, input int i);
    return {32'hD00D_0000 | 32'(i), a + 32'(i * 8)};
  endfunction

  function automatic logic [63:0] wbeat_v(input logic [31:0] a, input int i);
    return {32'hCAFE_0000 | 32'(i), a + 32'(i * 8)};
  endfunction

  task automatic rd_txn(input logic [31:0] a, input logic [2:0] sz, input logic [7:0] len,
                        input int ar_d, input int abort_at);
    rw_valid = 1'b1; rw_req = 1'b0; rw_addr = a; rw_size = sz; rw_len = len;
    tick;
    rw_valid = 1'b0;
    repeat (ar_d) tick;
    arready = 1'b1;
    tick;
    arready = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      repeat (gaps[i % 8]) tick;
      rvalid = 1'b1; rdata = rbeat(a, i); rlast = (i == int'(len)); rresp = 2'b00;
      if (i == abort_at) begin
        #2 rrst_n = 1'b0;
        #1;
        chk("async_rst_rready", 64'(rready), 64'd0);
        chk("async_rst_arvalid", 64'(arvalid), 64'd0);
        chk("async_rst_data", data_read, 64'd0);
        rvalid = 1'b0; rlast = 1'b0;
        @(posedge clk);
        #1 rrst_n = 1'b1;
        return;
      end
      tick;
    end
    rvalid = 1'b0; rlast = 1'b0;
    tick;
  endtask

  task automatic wr_accept(input logic [31:0] a, input logic [2:0] sz, input logic [7:0] len,
                           input logic [7:0] strb);
    rw_valid = 1'b1; rw_req = 1'b1; rw_addr = a; rw_size = sz; rw_len = len;
    w_strb = strb; rw_w_data = wbeat_v(a, 0);
    tick;
    rw_valid = 1'b0;
  endtask

  task automatic wr_rest(input logic [31:0] a, input logic [7:0] len, input int aw_d,
                         input int wstall, input logic [1:0] resp);
    repeat (aw_d) tick;
    awready = 1'b1;
    tick;
    awready = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      rw_w_data = wbeat_v(a, i);
      repeat (wstall) tick;
      wready = 1'b1;
      tick;
      wready = 1'b0;
    end
    tick;
    bvalid = 1'b1; bresp = resp;
    tick;
    bvalid = 1'b0; bresp = 2'b00;
    tick;
  endtask

  initial begin
    rw_valid = 1'b0; rw_req = 1'b0; rw_addr = 32'd0; rw_size = 3'd0; rw_len = 8'd0;
    rw_w_data = 64'd0; w_strb = 8'd0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    arready = 1'b0; rvalid = 1'b0; rdata = 64'd0; rlast = 1'b0; rresp = 2'b00;
    repeat (3) @(posedge clk);
    #1 rrst_n = 1'b1;
    tick;

    // Line refill with gapped beats, then a write-back accepted right after DONE.
    rd_txn(32'h8000_0040, 3'd3, 8'd7, 1, -1);
    chk("refill_last_beat", data_read, 64'hD00D_0007_8000_0078);
    wr_accept(32'h8000_0080, 3'd3, 8'd7, 8'hFF);
    wr_rest(32'h8000_0080, 8'd7, 1, 2, 2'b00);

    // UART byte store: unaligned address, one beat.
    wr_accept(32'h1000_0003, 3'd0, 8'd0, 8'h08);
    chk("uart_awaddr", 64'(awaddr), 64'h1000_0003);
    chk("uart_awlen", 64'(awlen), 64'd0);
    chk("uart_awsize", 64'(awsize), 64'd0);
    awready = 1'b1;
    tick;
    awready = 1'b0;
    chk("uart_wlast", 64'(wlast), 64'd1);
    chk("uart_wstrb", 64'(wstrb), 64'h08);
    chk("uart_wdata", wdata, 64'hCAFE_0000_1000_0003);
    wready = 1'b1;
    tick;
    wready = 1'b0;
    bvalid = 1'b1;
    tick;
    bvalid = 1'b0;
    chk("uart_rw_ready", 64'(rw_ready), 64'd1);
    tick;

    // Single-beat read: same-cycle arready and rlast in the first R cycle.
    rd_txn(32'h1000_0004, 3'd2, 8'd0, 0, -1);
    chk("mmio_read_data", data_read, 64'hD00D_0000_1000_0004);

    // Reset during beat 3, then a normal refill.
    rd_txn(32'h8000_0100, 3'd3, 8'd7, 2, 3);
    rd_txn(32'h8000_0200, 3'd3, 8'd7, 0, -1);
    chk("post_reset_data", data_read, 64'hD00D_0007_8000_0238);

    // Error response followed by a clean write.
    wr_accept(32'h8000_0300, 3'd3, 8'd1, 8'hFF);
    wr_rest(32'h8000_0300, 8'd1, 0, 0, 2'b10);
    wr_accept(32'h8000_0340, 3'd3, 8'd1, 8'hFF);
    wr_rest(32'h8000_0340, 8'd1, 0, 1, 2'b00);

    repeat (2) tick;
    chk("completed_txns", 64'(n_done), 64'd7);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_22040632_axi_master.md
Name: ysyx_22040632_axi_master

Overview:
- Downstream of the data cache: turns the cache's single-request memory port (rw_valid/rw_req/rw_addr/rw_len) into AXI4 master channels with INCR bursts.
- Serves line refills (8 x 64-bit beats), line write-backs, and single-beat uncacheable MMIO accesses.
- Handles one outstanding transaction at a time.

Parameters:
- ID_W, 4, AXI ID width.
- AXI_ID, 0, constant ID driven on AWID/ARID.
- ADDR_W, 32, address width.
- DATA_W, 64, data width.

Ports:
- clk  in  1  clock.
- rrst_n  in  1  reset.
- rw_valid  in  1  request valid from cache.
- rw_req  in  1  0=REQ_READ, 1=REQ_WRITE.
- rw_addr  in  ADDR_W  start address, passed unmodified.
- rw_size  in  3  AXI size code.
- rw_len  in  8  beats minus one.
- rw_w_data  in  DATA_W  current write beat.
- w_strb  in  DATA_W/8  write strobes.
- rw_ready  out  1  one-cycle completion pulse.
- data_read  out  DATA_W  last read beat, registered.
- r_hs  out  1  read beat handshake.
- r_last  out  1  final read beat handshake.
- w_hs  out  1  write beat handshake.
- w_last  out  1  final write beat handshake.
- axi_write_ahead  out  1  high in AW state.
- aw*/w*/b*/ar*/r*  AXI4 master channels: id, addr, len, size, burst, valid/ready, data, strb, last, resp.

Behaviour:
- Reset: clk and reset rrst_n, asynchronous, active-low. State IDLE; all AXI valids, rready, bready, rw_ready, r_hs, w_hs, r_last, w_last = 0; data_read = 0; beat_cnt = 0.
- FSM states: IDLE, AR, R, AW, W, B, DONE.
- IDLE:
  - rw_valid && rw_req==READ -> AR.
  - rw_valid && rw_req==WRITE -> AW.
  - Latch addr, size, len on acceptance.
  - rw_valid is ignored in every state except IDLE.
- AR: arvalid=1 with latched fields, arburst=INCR. On arready go to R; arvalid drops the same edge.
- R:
  - rready=1.
  - r_hs = rvalid&&rready, combinational.
  - data_read <= rdata on each r_hs and holds until the next beat.
  - r_last = r_hs&&rlast.
  - On r_last go to DONE.
- AW:
  - awvalid=1.
  - axi_write_ahead=1, so the cache presents beat 0 by the first W cycle.
  - On awready go to W; beat_cnt=0.
- W:
  - wvalid=1, wdata=rw_w_data, wstrb=w_strb, wlast=(beat_cnt==len).
  - w_hs = wvalid&&wready; beat_cnt increments on w_hs.
  - w_last = w_hs&&wlast.
  - On w_last go to B.
- B: bready=1. On bvalid go to DONE.
- DONE: rw_ready=1 for exactly one cycle, then IDLE. The cache drops rw_valid in that same cycle.
- Latency: rw_ready is one cycle after the final R or B handshake.
- Data/beat rules:
  - rlast is authoritative for reads; reads do not use the beat counter.
  - beat_cnt is 8-bit and never exceeds len.
  - wvalid stays asserted until wready, with data stable.
- Boundary cases:
  - len=0 (uncacheable): a single beat with wlast=1.
  - Byte-addressed accesses (size 0) pass the unaligned address unchanged.
  - arready/awready asserted in the same cycle as valid rise: single-cycle handshake.
  - Simultaneous rvalid&&rlast in the first R cycle: DONE next.
- Reset mid-burst: immediate return to IDLE, all valids drop. The interconnect is reset by the same rrst_n.

Optional Feature:
- YSYX_22040632_AXI_RESP_CHECK_EN.
- Defined:
  - Adds output rw_err.
  - rw_err is sticky within a transaction and is set on any rresp/bresp != OKAY.
  - It is valid alongside rw_ready and cleared on the next IDLE acceptance.
- Undefined: resp is ignored and there is no rw_err port.

Decomposition:
- Shared package:
  - REQ_READ/REQ_WRITE.
  - AXI_SIZE_BYTES_1/2/4/8.
  - AXI_BURST_INCR=2'b01.
  - AXI_RESP_OKAY=2'b00.
  - State enum type.
- Single module; no sub-module. The FSM and beat counter are small.

Test Plan:
- Read burst: rw_addr=0x8000_0040, len=7, size=8B, slave returns beats 0..7 with random rvalid gaps -> ARLEN=7, ARBURST=INCR; 8 r_hs pulses; data_read matches each beat; r_last on beat 7; rw_ready one cycle after.
- Write-back: len=7, slave delays wready 2 cycles per beat -> axi_write_ahead in AW; wlast only on 8th beat; WDATA stable while stalled; bvalid -> rw_ready pulse.
- UART byte write: addr=0x1000_0003, size=1B, len=0, w_strb=0x08 -> AWADDR=0x1000_0003, single beat with WLAST=1, WSTRB=0x08.
- Back-to-back: read completes, new write rw_valid the cycle after DONE -> accepted from IDLE; no request dropped or duplicated.
- Reset asserted during beat 3 of a read -> all valids 0 asynchronously; IDLE after release; next request behaves normally.
- With YSYX_22040632_AXI_RESP_CHECK_EN: bresp=SLVERR -> rw_err=1 with rw_ready; next OKAY transaction -> rw_err=0.
